// File: rtl/mul_issue_ctrl_pkg.sv
// Shared definitions for the multiplier issue controller: op codes, signedness
// codes, FSM states and small operand/result formatting helpers.
package mul_issue_ctrl_pkg;

  // RV64M multiply op codes as presented on req_op
  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpMulhu  = 3'b011;
  localparam logic [2:0] OpMulw   = 3'b100;

  // Cycles from the start pulse being accepted by the multiplier to its done pulse,
  // counted from the accept of the request
  localparam int unsigned MulLatency = 6;

  // Signedness code driven to the multiplier
  typedef enum logic [1:0] {
    ModeUU = 2'b00,
    ModeSU = 2'b01,
    ModeSS = 2'b10
  } mul_mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StDone,
    StDrain
  } state_e;

  function automatic logic op_legal(logic [2:0] op);
    return op <= OpMulw;
  endfunction

  function automatic mul_mode_e op_mode(logic [2:0] op);
    case (op)
      OpMulhu:  return ModeUU;
      OpMulhsu: return ModeSU;
      default:  return ModeSS;
    endcase
  endfunction

  function automatic logic [63:0] sext32(logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Pick the half of the product each op returns
  function automatic logic [63:0] fmt_result(logic [2:0] op, logic [63:0] hi, logic [63:0] lo);
    case (op)
      OpMul:   return lo;
      OpMulw:  return sext32(lo[31:0]);
      default: return hi;
    endcase
  endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// EXU-side request/response handshake bundle of the multiplier issue controller.
interface mul_issue_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [63:0] req_src1;
  logic [63:0] req_src2;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;

  // EXU side
  modport master (
    output req_valid, req_op, req_src1, req_src2, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  // Controller side
  modport slave (
    input  req_valid, req_op, req_src1, req_src2, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/mul_reuse_cache.sv
// Single-entry hi/lo product cache. A MUL following any op on the same operands
// reuses the low half; MULH/MULHSU/MULHU reuse the high half only when the
// signedness matches. MULW never hits.
module mul_reuse_cache
  import mul_issue_ctrl_pkg::*;
#(
  parameter bit REUSE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  lk_op,
  input  logic [63:0] lk_src1,
  input  logic [63:0] lk_src2,
  output logic        hit,
  output logic [63:0] hit_data,
  input  logic        wr_en,
  input  mul_mode_e   wr_mode,
  input  logic [63:0] wr_src1,
  input  logic [63:0] wr_src2,
  input  logic [63:0] wr_hi,
  input  logic [63:0] wr_lo
);

  logic        valid_q;
  mul_mode_e   mode_q;
  logic [63:0] src1_q, src2_q, hi_q, lo_q;
  logic        tag_match;

  // Entry storage; only reset invalidates it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      mode_q  <= ModeUU;
      src1_q  <= '0;
      src2_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (wr_en) begin
      valid_q <= 1'b1;
      mode_q  <= wr_mode;
      src1_q  <= wr_src1;
      src2_q  <= wr_src2;
      hi_q    <= wr_hi;
      lo_q    <= wr_lo;
    end
  end

  // Tag compare and half select
  always_comb begin
    tag_match = valid_q && (lk_src1 == src1_q) && (lk_src2 == src2_q);
    hit       = 1'b0;
    hit_data  = hi_q;
    if (REUSE_EN) begin
      case (lk_op)
        OpMul: begin
          // Low half of the product does not depend on signedness
          hit      = tag_match;
          hit_data = lo_q;
        end
        OpMulh, OpMulhsu, OpMulhu: hit = tag_match && (mode_q == op_mode(lk_op));
        default: hit = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Sequencing controller between the EXU and the 64-bit multiplier datapath:
// accepts RV64M multiply requests, issues them with a one-cycle start pulse,
// waits for the done pulse and returns the formatted result with backpressure.
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 16,
  parameter bit          REUSE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  mul_issue_ctrl_if.slave   exu,
  input  logic              flush,
  output logic              busy,
  output logic              timeout_err,
  output logic              mul_valid_in,
  output logic [1:0]        mul_signed,
  output logic [63:0]       mul_multiplicand,
  output logic [63:0]       mul_multiplier,
  input  logic              mul_valid_out,
  input  logic [63:0]       mul_result_hi,
  input  logic [63:0]       mul_result_lo
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [63:0]     src1_q, src1_d, src2_q, src2_d;
  logic [63:0]     res_q, res_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            terr_q, terr_d;

  logic            accept, in_flight, timed_out, cache_wr;
  logic            hit;
  logic [63:0]     hit_data;

  assign accept    = exu.req_valid && exu.req_ready;
  assign in_flight = (state_q == StIssue) || (state_q == StWait) || (state_q == StDrain);
  assign timed_out = (cnt_q == CntW'(TIMEOUT - 1));

  // Lookup uses the live request so a hit can answer on the cycle after accept
  mul_reuse_cache #(
    .REUSE_EN (REUSE_EN)
  ) u_cache (
    .clk      (clk),
    .rst      (rst),
    .lk_op    (exu.req_op),
    .lk_src1  (exu.req_src1),
    .lk_src2  (exu.req_src2),
    .hit      (hit),
    .hit_data (hit_data),
    .wr_en    (cache_wr),
    .wr_mode  (op_mode(op_q)),
    .wr_src1  (src1_q),
    .wr_src2  (src2_q),
    .wr_hi    (mul_result_hi),
    .wr_lo    (mul_result_lo)
  );

  // State, captured request, result and timeout registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  // Next-state logic, result capture and cache write decision
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    terr_d   = terr_q;
    cache_wr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d   = exu.req_op;
          src1_d = exu.req_src1;
          src2_d = exu.req_src2;
          if (!op_legal(exu.req_op)) begin
            res_d   = '0;
            state_d = StDone;
          end else if (hit) begin
            res_d   = hit_data;
            state_d = StDone;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = flush ? StDrain : StWait;
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (mul_valid_out) begin
          if (flush) begin
            state_d = StIdle;
          end else begin
            res_d    = fmt_result(op_q, mul_result_hi, mul_result_lo);
            cache_wr = (op_q != OpMulw);
            state_d  = StDone;
          end
        end else if (flush) begin
          state_d = StDrain;
        end else if (timed_out) begin
          terr_d  = 1'b1;
          res_d   = '0;
          state_d = StDone;
        end
      end
      StDrain: begin
        cnt_d = cnt_q + CntW'(1);
        if (mul_valid_out) begin
          state_d = StIdle;
        end else if (timed_out) begin
          terr_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StDone: begin
        // Flush and resp_ready both retire the response; flush just drops it
        if (flush || exu.resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs; rst gates req_ready so every output reads 0 while reset is held
  always_comb begin
    exu.req_ready    = rst && (state_q == StIdle) && !flush;
    exu.resp_valid   = (state_q == StDone);
    exu.resp_data    = (state_q == StDone) ? res_q : '0;
    busy             = (state_q != StIdle);
    timeout_err      = terr_q;
    mul_valid_in     = (state_q == StIssue);
    mul_signed       = in_flight ? op_mode(op_q) : ModeUU;
    mul_multiplicand = '0;
    mul_multiplier   = '0;
    if (in_flight) begin
      mul_multiplicand = (op_q == OpMulw) ? sext32(src1_q[31:0]) : src1_q;
      mul_multiplier   = (op_q == OpMulw) ? sext32(src2_q[31:0]) : src2_q;
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Scoreboard bench for mul_issue_ctrl: directed requests push expected results,
// a monitor pops and compares on every accepted response, and a behavioural
// multiplier answers each start pulse after a fixed latency.
module tb_mul_issue_ctrl;
  import mul_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, busy, timeout_err;
  logic        mul_valid_in, mul_valid_out;
  logic [1:0]  mul_signed;
  logic [63:0] mul_multiplicand, mul_multiplier, mul_result_hi, mul_result_lo;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  bit          hold_done = 1'b0;

  localparam logic [63:0] AllOnes = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MinusThree = 64'hFFFF_FFFF_FFFF_FFFD;

  always #5 clk = ~clk;

  mul_issue_ctrl_if bus ();

  mul_issue_ctrl #(
    .TIMEOUT  (16),
    .REUSE_EN (1'b1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .exu              (bus),
    .flush            (flush),
    .busy             (busy),
    .timeout_err      (timeout_err),
    .mul_valid_in     (mul_valid_in),
    .mul_signed       (mul_signed),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_valid_out    (mul_valid_out),
    .mul_result_hi    (mul_result_hi),
    .mul_result_lo    (mul_result_lo)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [127:0] model_mul(input logic [1:0] mode, input logic [63:0] a,
                                             input logic [63:0] b);
    logic [127:0] ea, eb;
    ea = (mode != 2'b00) ? {{64{a[63]}}, a} : {64'b0, a};
    eb = (mode == 2'b10) ? {{64{b[63]}}, b} : {64'b0, b};
    return ea * eb;
  endfunction

  // Behavioural multiplier: done pulse MulLatency cycles after the request accept
  initial begin
    int unsigned  mcnt;
    logic [127:0] prod;
    mcnt          = 0;
    prod          = '0;
    mul_valid_out = 1'b0;
    mul_result_hi = '0;
    mul_result_lo = '0;
    forever begin
      @(negedge clk);
      mul_valid_out = 1'b0;
      if (!rst) begin
        mcnt = 0;
      end else begin
        if (mcnt > 0) begin
          mcnt--;
          if (mcnt == 0 && !hold_done) begin
            mul_valid_out = 1'b1;
            mul_result_hi = prod[127:64];
            mul_result_lo = prod[63:0];
          end
        end
        if (mul_valid_in) begin
          prod = model_mul(mul_signed, mul_multiplicand, mul_multiplier);
          mcnt = MulLatency - 1;
        end
      end
    end
  end

  // Monitor: every accepted response is compared against the scoreboard head
  always @(negedge clk) begin
    if (rst && bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got %h, expected no response", bus.resp_data);
      end else begin
        chk("resp_data", bus.resp_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send(input string name, input logic [2:0] op, input logic [63:0] a,
                      input logic [63:0] b);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_src1  = a;
    bus.req_src2  = b;
    @(negedge clk);
    chk({name, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'b000;
    bus.req_src1  = '0;
    bus.req_src2  = '0;
  endtask

  // Issue one op, check start pulse, operands and response latency, optionally hold
  // resp_ready low for `hold` cycles checking stability, then release (or not).
  task automatic run_op(input string name, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input int exp_starts, input logic [1:0] exp_mode,
                        input logic [63:0] exp_a, input logic [63:0] exp_b, input int exp_lat,
                        input logic [63:0] exp_data, input int hold, input bit sb,
                        input bit release_resp);
    int starts      = 0;
    int first_start = -1;
    int resp_off    = -1;
    if (sb) exp_q.push_back(exp_data);
    send(name, op, a, b);
    for (int k = 1; k <= 40 && resp_off < 0; k++) begin
      @(negedge clk);
      if (mul_valid_in) begin
        starts++;
        if (first_start < 0) first_start = k;
        if (k == 1) begin
          chk({name, "_mul_signed"}, 64'(mul_signed), 64'(exp_mode));
          chk({name, "_multiplicand"}, mul_multiplicand, exp_a);
          chk({name, "_multiplier"}, mul_multiplier, exp_b);
        end
      end
      if (bus.resp_valid) resp_off = k;
    end
    chk({name, "_starts"}, 64'(starts), 64'(exp_starts));
    chk({name, "_start_cycle"}, 64'(first_start), (exp_starts > 0) ? 64'd1 : AllOnes);
    chk({name, "_resp_latency"}, 64'(resp_off), 64'(exp_lat));
    if (resp_off < 0) return;
    for (int h = 0; h < hold; h++) begin
      chk({name, "_hold_valid"}, 64'(bus.resp_valid), 64'd1);
      chk({name, "_hold_data"}, bus.resp_data, exp_data);
      chk({name, "_hold_req_ready"}, 64'(bus.req_ready), 64'd0);
      @(negedge clk);
    end
    if (!release_resp) return;
    if (!bus.resp_ready) begin
      @(posedge clk);
      #1;
      bus.resp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b0;
    flush          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 3'b000;
    bus.req_src1   = '0;
    bus.req_src2   = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);

    // Reset state
    @(negedge clk);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mul_valid_in", 64'(mul_valid_in), 64'd0);
    chk("rst_operand_a", mul_multiplicand, 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;

    // MULHU: (2^64-1)*2 -> hi = 1
    run_op("mulhu", OpMulhu, AllOnes, 64'd2, 1, 2'b00, AllOnes, 64'd2, 7, 64'd1, 0, 1, 1);

    // MULH -3*5 -> hi all ones; MUL on same operands reuses lo from the cache
    run_op("mulh", OpMulh, MinusThree, 64'd5, 1, 2'b10, MinusThree, 64'd5, 7, AllOnes, 0, 1, 1);
    run_op("mul_hit", OpMul, MinusThree, 64'd5, 0, 2'b00, 64'd0, 64'd0, 1,
           64'hFFFF_FFFF_FFFF_FFF1, 0, 1, 1);

    // MULHSU: signed -1 times unsigned 2 -> hi all ones; MUL hits across modes
    run_op("mulhsu", OpMulhsu, AllOnes, 64'd2, 1, 2'b01, AllOnes, 64'd2, 7, AllOnes, 0, 1, 1);
    run_op("mul_hit_su", OpMul, AllOnes, 64'd2, 0, 2'b00, 64'd0, 64'd0, 1,
           64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 1);

    // MULW operand truncation; cache must not be written, so MUL then issues
    run_op("mulw", OpMulw, 64'h1_0000_0003, 64'h7FFF_FFFF, 1, 2'b10, 64'd3, 64'h7FFF_FFFF, 7,
           64'h0000_0000_7FFF_FFFD, 0, 1, 1);
    run_op("mul_after_w", OpMul, 64'h1_0000_0003, 64'h7FFF_FFFF, 1, 2'b10, 64'h1_0000_0003,
           64'h7FFF_FFFF, 7, 64'h8000_0000_7FFF_FFFD, 0, 1, 1);
    run_op("mulw_neg", OpMulw, 64'd2, 64'hC000_0000, 1, 2'b10, 64'd2, 64'hFFFF_FFFF_C000_0000, 7,
           64'hFFFF_FFFF_8000_0000, 0, 1, 1);

    // Flush in WAIT at T+3: drain until done pulse at T+6, idle at T+7, no response
    send("flush", OpMul, 64'd7, 64'd9);
    @(negedge clk);
    chk("flush_start", 64'(mul_valid_in), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_t3_req_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    for (int k = 4; k <= 6; k++) begin
      @(negedge clk);
      chk("drain_req_ready", 64'(bus.req_ready), 64'd0);
      chk("drain_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("drain_busy", 64'(busy), 64'd1);
    end
    @(negedge clk);
    chk("drain_done_req_ready", 64'(bus.req_ready), 64'd1);
    chk("drain_done_busy", 64'(busy), 64'd0);
    chk("drain_done_resp_valid", 64'(bus.resp_valid), 64'd0);
    @(posedge clk);
    #1;
    // Drained result must not have been cached
    run_op("mul_after_flush", OpMul, 64'd7, 64'd9, 1, 2'b10, 64'd7, 64'd9, 7, 64'd63, 0, 1, 1);

    // Backpressure: resp_ready low for 4 cycles in DONE
    bus.resp_ready = 1'b0;
    run_op("mulhu_hold", OpMulhu, AllOnes, 64'd2, 1, 2'b00, AllOnes, 64'd2, 7, 64'd1, 4, 1, 1);

    // Illegal op answers 0 on the next cycle without issuing
    run_op("illegal", 3'b111, 64'd1, 64'd2, 0, 2'b00, 64'd0, 64'd0, 1, 64'd0, 0, 1, 1);

    // Lost done pulse: timeout after 16 WAIT cycles, then reset mid-DONE
    chk("pre_timeout_err", 64'(timeout_err), 64'd0);
    hold_done      = 1'b1;
    bus.resp_ready = 1'b0;
    run_op("timeout", OpMulh, 64'd5, 64'd6, 1, 2'b10, 64'd5, 64'd6, 18, 64'd0, 2, 0, 0);
    chk("timeout_err_set", 64'(timeout_err), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("arst_resp_data", bus.resp_data, 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_timeout_err", 64'(timeout_err), 64'd0);
    chk("arst_req_ready", 64'(bus.req_ready), 64'd0);
    hold_done      = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Cache was invalidated by reset, so this issues again
    run_op("mul_post_rst", OpMul, 64'd7, 64'd9, 1, 2'b10, 64'd7, 64'd9, 7, 64'd63, 0, 1, 1);

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
